csr_exec_unit: RTL and testbench
================================

Name: csr_exec_unit

Overview:
Executes the Zicsr accesses issued by the CSR decoder: it consumes CSRwe/CSRre/CSRop and performs the read-modify-write on the machine-mode CSR file. It also handles trap entry and mret, and exposes mtvec, mepc and interrupt-pending to the control FSM. It sits beside the datapath in the kianv multicycle core. Read data returns one cycle after the access.

Parameters:
HART_ID, 0, value returned by mhartid (0xF14)
MISA_VAL, 32'h40001101, constant returned by misa (RV32IMA)

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
CSRwe  in  1  write enable from decoder (already valid-gated)
CSRre  in  1  read enable from decoder (already valid-gated)
CSRop  in  CSR_OP_WIDTH(3)  operation code
csr_addr  in  12  CSR address (instr[31:20])
rs1_data  in  32  register source operand
uimm  in  5  immediate source operand (instr[19:15])
instret_inc  in  1  one instruction retired this cycle
trap_valid  in  1  trap entry strobe
trap_cause  in  32  mcause value for the trap
trap_pc  in  32  faulting/interrupted pc
trap_val  in  32  mtval value
mret  in  1  mret strobe
irq_msip, irq_mtip, irq_meip  in  1 each  level interrupt sources (mip bits 3, 7, 11)
csr_rdata  out  32  read data
csr_rdata_valid  out  1  rdata strobe
csr_illegal  out  1  illegal-access strobe
mtvec_o  out  32  current mtvec
mepc_o  out  32  current mepc
irq_pending  out  1  mstatus.MIE & |(mie & mip)

Behaviour:
- Reset (async, resetn=0): all CSRs 0 except the constants; csr_rdata=0, csr_rdata_valid=0, csr_illegal=0.
- Access at cycle N (CSRwe|CSRre): csr_rdata/csr_rdata_valid registered at N+1, pulse one cycle. Read returns the pre-write value.
- Source operand: src = {27'b0,uimm} for RWI/RSI/RCI, else rs1_data.
- New value: RW/RWI src; RS/RSI old|src; RC/RCI old&~src. Applied only if CSRwe; visible from N+1.
- CSRre=0 with CSRwe=1: no read, csr_rdata_valid stays 0. CSRop=NA: no effect.
- Implemented registers:
  - mstatus 0x300: writable bits MIE[3], MPIE[7]; MPP[12:11] reads 2'b11.
  - misa 0x301: read-only constant; writes ignored, not illegal.
  - mie 0x304: bits 3, 7, 11 writable.
  - mtvec 0x305: [1:0] forced 0.
  - mscratch 0x340.
  - mepc 0x341: [1:0] forced 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only, live inputs; writes ignored.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82: read-only aliases.
  - mhartid 0xF14: HART_ID.
- Illegal: unimplemented address with access, or CSRwe with csr_addr[11:10]==2'b11. Then csr_illegal pulses at N+1, csr_rdata=0, csr_rdata_valid=0, no state change.
- Counters:
  - 64-bit mcycle increments every cycle; minstret increments on instret_inc.
  - A write to either half replaces that half only, and that counter does not increment that cycle (write wins).
  - Wrap at 2^64-1 to 0.
- Trap entry (trap_valid):
  - mepc <= trap_pc&~3, mcause <= trap_cause, mtval <= trap_val.
  - MPIE <= MIE, MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1.
- Simultaneous events:
  - trap_valid beats mret.
  - trap_valid beats a same-cycle CSR write (write dropped; read still returns the old value).
  - mret beats a CSR write to mstatus.
- mtvec_o/mepc_o/irq_pending reflect registered state (combinational from flops).
- Reset mid-access: all pending strobes clear immediately.

Decomposition:
- Shared package (riscv_defines.vh):
  - CSR_OP_WIDTH=3.
  - CSR_OP_NA=0, CSRRW=1, CSRRS=2, CSRRC=3, CSRRWI=5, CSRRSI=6, CSRRCI=7.
  - CSR address constants; mstatus bit positions MIE=3, MPIE=7.
- One natural sub-module: csr_counter64 (64-bit counter with increment and per-half write), instantiated twice for mcycle and minstret.

Test Plan:
- Reset then CSRRW mscratch, rs1_data=0xDEADBEEF, CSRre=1 -> N+1 rdata=0, valid=1; next read of mscratch returns 0xDEADBEEF.
- mscratch=0xF0F0F0F0; CSRRCI uimm=5'h0F -> rdata=0xF0F0F0F0; then CSRRS x0 (we=0) reads 0xF0F0F0F0 with no write.
- Write 0x12345678 to mcycle at N -> read at N+3 returns 0x1234567A; minstreth=0xFFFFFFFF, minstret=0xFFFFFFFF, instret_inc -> both halves read 0.
- mstatus.MIE=1; trap_valid with trap_pc=0x80000106, cause=0x80000007 -> mepc=0x80000104, mcause=0x80000007, MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1.
- Access 0x7C0, or write 0xC00 -> csr_illegal=1 at N+1, rdata_valid=0, no state change.
- mie=0x80, MIE=1, irq_mtip=1 -> irq_pending=1; same-cycle trap_valid and CSRRW mtvec=0x100 -> trap applied, mtvec unchanged.

Source files
------------

// File: rtl/csr_exec_unit_pkg.sv
// Shared Zicsr definitions: operation codes, machine-mode CSR addresses and
// the read-modify-write helper used by the CSR execution unit.
package csr_exec_unit_pkg;

   localparam int CSR_OP_WIDTH = 3;

   typedef enum logic [CSR_OP_WIDTH-1:0] {
      CSR_OP_NA = 3'd0,
      CSRRW     = 3'd1,
      CSRRS     = 3'd2,
      CSRRC     = 3'd3,
      CSRRWI    = 3'd5,
      CSRRSI    = 3'd6,
      CSRRCI    = 3'd7
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // Only MSIE, MTIE and MEIE exist in this hart.
   localparam logic [31:0] MIE_MASK = 32'h0000_0888;

   function automatic logic csr_op_valid(input csr_op_e op);
      case (op)
         CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI: csr_op_valid = 1'b1;
         default:                                    csr_op_valid = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] csr_apply(input csr_op_e op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] src);
      case (op)
         CSRRW, CSRRWI: csr_apply = src;
         CSRRS, CSRRSI: csr_apply = old_val | src;
         CSRRC, CSRRCI: csr_apply = old_val & ~src;
         default:       csr_apply = old_val;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves; a write
// to either half suppresses the increment for that cycle.
module csr_counter64 (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] count
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (wr_lo) begin
         count[31:0] <= wdata;
      end else if (wr_hi) begin
         count[63:32] <= wdata;
      end else if (inc) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/csr_exec_unit.sv
// Machine-mode CSR file with Zicsr read-modify-write, trap entry and mret.
// Read data and the illegal strobe are registered one cycle after the access.
module csr_exec_unit
   import csr_exec_unit_pkg::*;
#(
   parameter logic [31:0] HART_ID  = 32'd0,
   parameter logic [31:0] MISA_VAL = 32'h4000_1101
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    CSRwe,
   input  logic                    CSRre,
   input  logic [CSR_OP_WIDTH-1:0] CSRop,
   input  logic [11:0]             csr_addr,
   input  logic [31:0]             rs1_data,
   input  logic [4:0]              uimm,
   input  logic                    instret_inc,
   input  logic                    trap_valid,
   input  logic [31:0]             trap_cause,
   input  logic [31:0]             trap_pc,
   input  logic [31:0]             trap_val,
   input  logic                    mret,
   input  logic                    irq_msip,
   input  logic                    irq_mtip,
   input  logic                    irq_meip,
   output logic [31:0]             csr_rdata,
   output logic                    csr_rdata_valid,
   output logic                    csr_illegal,
   output logic [31:0]             mtvec_o,
   output logic [31:0]             mepc_o,
   output logic                    irq_pending
);

   csr_op_e     op;
   logic        access;
   logic        implemented;
   logic        illegal;
   logic        wr_en;
   logic [31:0] old_val;
   logic [31:0] src;
   logic [31:0] new_val;
   logic [31:0] mstatus_val;
   logic [31:0] mip_val;

   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic [31:0] mie_q;
   logic [31:0] mtvec_q;
   logic [31:0] mscratch_q;
   logic [31:0] mepc_q;
   logic [31:0] mcause_q;
   logic [31:0] mtval_q;
   logic [63:0] mcycle;
   logic [63:0] minstret;

   assign op = csr_op_e'(CSRop);

   // MPP is hardwired to machine mode since no other privilege level exists.
   assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
   assign mip_val     = {20'b0, irq_meip, 3'b0, irq_mtip, 3'b0, irq_msip, 3'b0};

   always_comb begin
      old_val     = '0;
      implemented = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:                old_val = mstatus_val;
         CSR_MISA:                   old_val = MISA_VAL;
         CSR_MIE:                    old_val = mie_q;
         CSR_MTVEC:                  old_val = mtvec_q;
         CSR_MSCRATCH:               old_val = mscratch_q;
         CSR_MEPC:                   old_val = mepc_q;
         CSR_MCAUSE:                 old_val = mcause_q;
         CSR_MTVAL:                  old_val = mtval_q;
         CSR_MIP:                    old_val = mip_val;
         CSR_MCYCLE,   CSR_CYCLE:    old_val = mcycle[31:0];
         CSR_MCYCLEH,  CSR_CYCLEH:   old_val = mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:  old_val = minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
         CSR_MHARTID:                old_val = HART_ID;
         default:                    implemented = 1'b0;
      endcase
   end

   // A trap in the same cycle drops the write but still lets the read through.
   always_comb begin
      access  = (CSRwe | CSRre) & csr_op_valid(op);
      illegal = access & (~implemented | (CSRwe & (csr_addr[11:10] == 2'b11)));
      src     = (op == CSRRWI || op == CSRRSI || op == CSRRCI) ? {27'b0, uimm} : rs1_data;
      new_val = csr_apply(op, old_val, src);
      wr_en   = access & CSRwe & ~illegal & ~trap_valid;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         csr_rdata       <= '0;
         csr_rdata_valid <= 1'b0;
         csr_illegal     <= 1'b0;
      end else begin
         csr_rdata       <= (access & CSRre & ~illegal) ? old_val : 32'd0;
         csr_rdata_valid <= access & CSRre & ~illegal;
         csr_illegal     <= illegal;
      end
   end

   // Priority: trap entry, then mret, then software writes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_q        <= '0;
         mtvec_q      <= '0;
         mscratch_q   <= '0;
         mepc_q       <= '0;
         mcause_q     <= '0;
         mtval_q      <= '0;
      end else if (trap_valid) begin
         mepc_q       <= trap_pc & ~32'd3;
         mcause_q     <= trap_cause;
         mtval_q      <= trap_val;
         mstatus_mpie <= mstatus_mie;
         mstatus_mie  <= 1'b0;
      end else begin
         if (mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end
         if (wr_en) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  if (!mret) begin
                     mstatus_mie  <= new_val[MSTATUS_MIE];
                     mstatus_mpie <= new_val[MSTATUS_MPIE];
                  end
               end
               CSR_MIE:      mie_q      <= new_val & MIE_MASK;
               CSR_MTVEC:    mtvec_q    <= new_val & ~32'd3;
               CSR_MSCRATCH: mscratch_q <= new_val;
               CSR_MEPC:     mepc_q     <= new_val & ~32'd3;
               CSR_MCAUSE:   mcause_q   <= new_val;
               CSR_MTVAL:    mtval_q    <= new_val;
               default: ;
            endcase
         end
      end
   end

   csr_counter64 u_mcycle (
      .clk    (clk),
      .resetn (resetn),
      .inc    (1'b1),
      .wr_lo  (wr_en && csr_addr == CSR_MCYCLE),
      .wr_hi  (wr_en && csr_addr == CSR_MCYCLEH),
      .wdata  (new_val),
      .count  (mcycle)
   );

   csr_counter64 u_minstret (
      .clk    (clk),
      .resetn (resetn),
      .inc    (instret_inc),
      .wr_lo  (wr_en && csr_addr == CSR_MINSTRET),
      .wr_hi  (wr_en && csr_addr == CSR_MINSTRETH),
      .wdata  (new_val),
      .count  (minstret)
   );

   assign mtvec_o     = mtvec_q;
   assign mepc_o      = mepc_q;
   assign irq_pending = mstatus_mie & |(mie_q & mip_val);

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: each access pushes its expected
// {valid, illegal, rdata}; the observed response is queued one edge later.
module tb_csr_exec_unit;

   localparam logic [31:0] MISA = 32'h4000_1101;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        CSRwe = 1'b0;
   logic        CSRre = 1'b0;
   logic [2:0]  CSRop = 3'd0;
   logic [11:0] csr_addr = '0;
   logic [31:0] rs1_data = '0;
   logic [4:0]  uimm = '0;
   logic        instret_inc = 1'b0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_cause = '0;
   logic [31:0] trap_pc = '0;
   logic [31:0] trap_val = '0;
   logic        mret = 1'b0;
   logic        irq_msip = 1'b0;
   logic        irq_mtip = 1'b0;
   logic        irq_meip = 1'b0;
   logic [31:0] csr_rdata;
   logic        csr_rdata_valid;
   logic        csr_illegal;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic        irq_pending;

   int checks = 0;
   int errors = 0;

   logic [33:0] exp_q[$];
   logic [33:0] obs_q[$];
   string       tag_q[$];

   csr_exec_unit dut (
      .clk             (clk),
      .resetn          (resetn),
      .CSRwe           (CSRwe),
      .CSRre           (CSRre),
      .CSRop           (CSRop),
      .csr_addr        (csr_addr),
      .rs1_data        (rs1_data),
      .uimm            (uimm),
      .instret_inc     (instret_inc),
      .trap_valid      (trap_valid),
      .trap_cause      (trap_cause),
      .trap_pc         (trap_pc),
      .trap_val        (trap_val),
      .mret            (mret),
      .irq_msip        (irq_msip),
      .irq_mtip        (irq_mtip),
      .irq_meip        (irq_meip),
      .csr_rdata       (csr_rdata),
      .csr_rdata_valid (csr_rdata_valid),
      .csr_illegal     (csr_illegal),
      .mtvec_o         (mtvec_o),
      .mepc_o          (mepc_o),
      .irq_pending     (irq_pending)
   );

   always #5 clk = ~clk;

   // Drive one access for a single cycle and record the registered response.
   task automatic issue(input logic we, input logic re, input logic [2:0] op,
                        input logic [11:0] addr, input logic [31:0] rs1,
                        input logic [4:0] imm, input logic exp_v,
                        input logic exp_i, input logic [31:0] exp_d,
                        input string tag);
      @(negedge clk);
      CSRwe = we; CSRre = re; CSRop = op; csr_addr = addr;
      rs1_data = rs1; uimm = imm;
      exp_q.push_back({exp_v, exp_i, exp_d});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      obs_q.push_back({csr_rdata_valid, csr_illegal, csr_rdata});
      CSRwe = 1'b0; CSRre = 1'b0; CSRop = 3'd0;
   endtask

   task automatic idle();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      string t;
      logic [33:0] e, o;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({csr_rdata_valid, csr_illegal, csr_rdata} !== 34'd0) begin
         errors++;
         $display("[TB] FAIL reset_strobes: got %h expected 0", {csr_rdata_valid, csr_illegal, csr_rdata});
      end
      checks++;
      if ({mtvec_o, mepc_o, irq_pending} !== 65'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: mtvec %h mepc %h pend %b expected zeros", mtvec_o, mepc_o, irq_pending);
      end
      resetn = 1'b1;
      issue(0, 1, 3'd2, 12'h300, 0, 0, 1, 0, 32'h0000_1800, "rst_mstatus");
      issue(0, 1, 3'd2, 12'h301, 0, 0, 1, 0, MISA, "rst_misa");
      issue(0, 1, 3'd2, 12'hF14, 0, 0, 1, 0, 32'd0, "rst_mhartid");
      issue(0, 1, 3'd2, 12'h340, 0, 0, 1, 0, 32'd0, "rst_mscratch");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", t, o, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      string t;
      logic [33:0] e, o;
      issue(1, 1, 3'd1, 12'h340, 32'hDEAD_BEEF, 0, 1, 0, 32'd0, "rw_first");
      issue(0, 1, 3'd2, 12'h340, 0, 0, 1, 0, 32'hDEAD_BEEF, "rw_readback");
      issue(1, 1, 3'd1, 12'h340, 32'hF0F0_F0F0, 0, 1, 0, 32'hDEAD_BEEF, "rw_second");
      issue(1, 1, 3'd7, 12'h340, 0, 5'h0F, 1, 0, 32'hF0F0_F0F0, "rci");
      issue(0, 1, 3'd2, 12'h340, 0, 0, 1, 0, 32'hF0F0_F0F0, "rs_x0");
      issue(1, 1, 3'd6, 12'h340, 0, 5'h0F, 1, 0, 32'hF0F0_F0F0, "rsi");
      issue(1, 1, 3'd3, 12'h340, 32'hFF00_0000, 0, 1, 0, 32'hF0F0_F0FF, "rc");
      issue(1, 0, 3'd1, 12'h340, 32'h1111_1111, 0, 0, 0, 32'd0, "we_only");
      issue(0, 1, 3'd2, 12'h340, 0, 0, 1, 0, 32'h1111_1111, "we_only_rb");
      issue(1, 1, 3'd0, 12'h340, 32'h2222_2222, 0, 0, 0, 32'd0, "op_na");
      issue(1, 1, 3'd1, 12'h340, 32'h00F0_F0FF, 0, 1, 0, 32'h1111_1111, "rw_restore");
      issue(1, 1, 3'd1, 12'h341, 32'h0000_0107, 0, 1, 0, 32'd0, "mepc_wr");
      issue(0, 1, 3'd2, 12'h341, 0, 0, 1, 0, 32'h0000_0104, "mepc_align");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", t, o, e);
         end
      end
   endtask

   task automatic test_counters();
      string t;
      logic [33:0] e, o;
      issue(1, 0, 3'd1, 12'hB00, 32'h1234_5678, 0, 0, 0, 32'd0, "mcycle_wr");
      idle();
      idle();
      issue(0, 1, 3'd2, 12'hB00, 0, 0, 1, 0, 32'h1234_567A, "mcycle_n3");
      issue(0, 1, 3'd2, 12'hC00, 0, 0, 1, 0, 32'h1234_567B, "cycle_alias");
      issue(1, 0, 3'd1, 12'hB82, 32'hFFFF_FFFF, 0, 0, 0, 32'd0, "minstreth_wr");
      issue(1, 0, 3'd1, 12'hB02, 32'hFFFF_FFFF, 0, 0, 0, 32'd0, "minstret_wr");
      instret_inc = 1'b1;
      idle();
      instret_inc = 1'b0;
      issue(0, 1, 3'd2, 12'hB02, 0, 0, 1, 0, 32'd0, "minstret_wrap_lo");
      issue(0, 1, 3'd2, 12'hB82, 0, 0, 1, 0, 32'd0, "minstret_wrap_hi");
      instret_inc = 1'b1;
      issue(1, 0, 3'd1, 12'hB02, 32'd5, 0, 0, 0, 32'd0, "minstret_wr_inc");
      instret_inc = 1'b0;
      issue(0, 1, 3'd2, 12'hC02, 0, 0, 1, 0, 32'd5, "write_wins");
      instret_inc = 1'b1;
      idle();
      instret_inc = 1'b0;
      issue(0, 1, 3'd2, 12'hB02, 0, 0, 1, 0, 32'd6, "minstret_inc");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", t, o, e);
         end
      end
   endtask

   task automatic test_trap_mret();
      string t;
      logic [33:0] e, o;
      issue(1, 1, 3'd6, 12'h300, 0, 5'h08, 1, 0, 32'h0000_1800, "mie_set");
      trap_valid = 1'b1; trap_pc = 32'h8000_0106; trap_cause = 32'h8000_0007;
      trap_val = 32'h0000_0BAD;
      idle();
      trap_valid = 1'b0;
      checks++;
      if (mepc_o !== 32'h8000_0104) begin
         errors++;
         $display("[TB] FAIL trap_mepc_o: got %h expected 80000104", mepc_o);
      end
      issue(0, 1, 3'd2, 12'h341, 0, 0, 1, 0, 32'h8000_0104, "trap_mepc");
      issue(0, 1, 3'd2, 12'h342, 0, 0, 1, 0, 32'h8000_0007, "trap_mcause");
      issue(0, 1, 3'd2, 12'h343, 0, 0, 1, 0, 32'h0000_0BAD, "trap_mtval");
      issue(0, 1, 3'd2, 12'h300, 0, 0, 1, 0, 32'h0000_1880, "trap_mstatus");
      mret = 1'b1;
      idle();
      mret = 1'b0;
      issue(0, 1, 3'd2, 12'h300, 0, 0, 1, 0, 32'h0000_1888, "mret_mstatus");
      mret = 1'b1;
      issue(1, 1, 3'd1, 12'h300, 32'd0, 0, 1, 0, 32'h0000_1888, "mret_vs_wr");
      mret = 1'b0;
      issue(0, 1, 3'd2, 12'h300, 0, 0, 1, 0, 32'h0000_1888, "mret_wins");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", t, o, e);
         end
      end
   endtask

   task automatic test_illegal();
      string t;
      logic [33:0] e, o;
      issue(1, 1, 3'd1, 12'h7C0, 32'h5555_5555, 0, 0, 1, 32'd0, "unimpl_addr");
      issue(1, 0, 3'd1, 12'hC00, 32'd5, 0, 0, 1, 32'd0, "ro_cycle_wr");
      issue(1, 1, 3'd1, 12'hF14, 32'd7, 0, 0, 1, 32'd0, "ro_hartid_wr");
      issue(0, 1, 3'd2, 12'hF14, 0, 0, 1, 0, 32'd0, "hartid_kept");
      issue(1, 1, 3'd1, 12'h301, 32'd0, 0, 1, 0, MISA, "misa_wr");
      issue(0, 1, 3'd2, 12'h301, 0, 0, 1, 0, MISA, "misa_kept");
      issue(1, 1, 3'd1, 12'h344, 32'hFFFF_FFFF, 0, 1, 0, 32'd0, "mip_wr");
      issue(0, 1, 3'd2, 12'h340, 0, 0, 1, 0, 32'h00F0_F0FF, "mscratch_kept");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", t, o, e);
         end
      end
   endtask

   task automatic test_irq_and_trap_priority();
      string t;
      logic [33:0] e, o;
      issue(1, 1, 3'd1, 12'h304, 32'hFFFF_FFFF, 0, 1, 0, 32'd0, "mie_wr_all");
      issue(1, 1, 3'd1, 12'h304, 32'h0000_0080, 0, 1, 0, 32'h0000_0888, "mie_mask");
      irq_mtip = 1'b1;
      #1;
      checks++;
      if (irq_pending !== 1'b1) begin
         errors++;
         $display("[TB] FAIL irq_mtip: got %b expected 1", irq_pending);
      end
      issue(0, 1, 3'd2, 12'h344, 0, 0, 1, 0, 32'h0000_0080, "mip_live");
      irq_mtip = 1'b0; irq_msip = 1'b1;
      #1;
      checks++;
      if (irq_pending !== 1'b0) begin
         errors++;
         $display("[TB] FAIL irq_msip_masked: got %b expected 0", irq_pending);
      end
      irq_msip = 1'b0; irq_mtip = 1'b1;
      issue(1, 1, 3'd1, 12'h305, 32'h0000_0203, 0, 1, 0, 32'd0, "mtvec_wr");
      issue(0, 1, 3'd2, 12'h305, 0, 0, 1, 0, 32'h0000_0200, "mtvec_align");
      trap_valid = 1'b1; trap_pc = 32'h0000_0043; trap_cause = 32'h8000_0007;
      trap_val = 32'd0;
      issue(1, 1, 3'd1, 12'h305, 32'h0000_0100, 0, 1, 0, 32'h0000_0200, "trap_vs_wr");
      trap_valid = 1'b0;
      checks++;
      if ({mtvec_o, irq_pending} !== {32'h0000_0200, 1'b0}) begin
         errors++;
         $display("[TB] FAIL trap_wins: mtvec %h pend %b expected 00000200 0", mtvec_o, irq_pending);
      end
      issue(0, 1, 3'd2, 12'h305, 0, 0, 1, 0, 32'h0000_0200, "mtvec_kept");
      issue(0, 1, 3'd2, 12'h341, 0, 0, 1, 0, 32'h0000_0040, "trap2_mepc");
      issue(0, 1, 3'd2, 12'h300, 0, 0, 1, 0, 32'h0000_1880, "trap2_mstatus");
      irq_mtip = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", t, o, e);
         end
      end
   endtask

   task automatic test_reset_mid_access();
      string t;
      logic [33:0] e, o;
      issue(0, 1, 3'd2, 12'h340, 0, 0, 1, 0, 32'h00F0_F0FF, "pre_reset_read");
      resetn = 1'b0;
      #1;
      checks++;
      if ({csr_rdata_valid, csr_illegal, csr_rdata, mepc_o} !== 66'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid: valid %b ill %b rdata %h mepc %h expected zeros",
                  csr_rdata_valid, csr_illegal, csr_rdata, mepc_o);
      end
      @(negedge clk);
      resetn = 1'b1;
      issue(0, 1, 3'd2, 12'h340, 0, 0, 1, 0, 32'd0, "post_reset_mscratch");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", t, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_counters();
      test_trap_mret();
      test_illegal();
      test_irq_and_trap_priority();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
